// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter with a small FIFO and fixed baud divider
module uart_tx #(
  parameter int ClkFreq   = 12000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [7:0]                         data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic [$clog2(FifoDepth+1)-1:0]     count_o
);
  localparam int BaudDiv = ClkFreq / BaudRate;
  localparam int CW = $clog2(BaudDiv);
  localparam int AW = $clog2(FifoDepth);
  localparam int NW = $clog2(FifoDepth + 1);

  if (BaudDiv < 2) begin : g_bad_baud
    $error("uart_tx: ClkFreq/BaudRate must be at least 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FifoDepth must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [FifoDepth];
  logic [AW-1:0]   wr_q, rd_q;
  logic [NW-1:0]   cnt_q;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic            tx_q, tx_d;
  logic            pop, push, full, expire;

  assign full    = cnt_q == NW'(FifoDepth);
  assign ready_o = !full && !reset_i;
  assign push    = valid_i && ready_o;
  assign expire  = baud_q == '0;
  assign count_o = cnt_q;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE) || (cnt_q != '0);

  // Frame sequencing: pick next state, line level, shifter and baud reload
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    baud_d  = expire ? CW'(BaudDiv - 1) : baud_q - 1'b1;
    unique case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        sh_d    = mem[rd_q];
        tx_d    = 1'b0;
        baud_d  = CW'(BaudDiv - 1);
        state_d = START;
      end
      START: if (expire) begin
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
        idx_d   = 3'd0;
        state_d = DATA;
      end
      DATA: if (expire) begin
        tx_d    = idx_q == 3'd7 ? 1'b1 : sh_q[0];
        sh_d    = sh_q >> 1;
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (expire) begin
        pop     = cnt_q != '0;
        sh_d    = cnt_q != '0 ? mem[rd_q] : sh_q;
        tx_d    = cnt_q == '0;
        state_d = cnt_q != '0 ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and FIFO bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      sh_q    <= '0;
      idx_q   <= '0;
      baud_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      baud_q  <= baud_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_q + NW'(push) - NW'(pop);
    end
  end

  // FIFO storage write; no reset needed since occupancy gates reads
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= data_i;
  end
endmodule
